pe_mac_pipe: RTL and testbench

//   Parametrised multiply-accumulate processing element; successor to the single-cycle pe.

---
 rtl/pe_mac_if.sv | 31 +++
 rtl/pe_mac_pipe.sv | 153 +++++++++++++++
 tb/tb_pe_mac_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_mac_if.sv
// Operand/result bundle for one MAC processing element.
// master drives beats and result acceptance; slave is the PE.
interface pe_mac_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              in_clear;
    logic              in_last;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic              fwd_valid;
    logic [ACC_W-1:0]  c;
    logic [ACC_W-1:0]  res_data;
    logic              res_valid;
    logic              res_ready;
    logic              sat_flag;

    modport master (
        output in_valid, a, b, in_clear, in_last, res_ready,
        input  in_ready, a_out, b_out, fwd_valid, c, res_data, res_valid, sat_flag
    );

    modport slave (
        input  in_valid, a, b, in_clear, in_last, res_ready,
        output in_ready, a_out, b_out, fwd_valid, c, res_data, res_valid, sat_flag
    );
endinterface

// File: rtl/pe_mac_pipe.sv
// Multiply-accumulate processing element with input handshake, optional product register,
// clear/last framing, saturation, backpressured result port and systolic operand forwarding.
module pe_mac_pipe #(
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 32,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 1,
    parameter int MUL_STAGE = 0
) (
    input logic     clk,
    input logic     rst,
    pe_mac_if.slave bus
);
    localparam int P_W = 2 * DATA_W;
    localparam int S_W = ((ACC_W > P_W) ? ACC_W : P_W) + 1;
    localparam bit SGN = (SIGNED != 0);
    localparam bit SAT = (SATURATE != 0);

    logic              in_ready;
    logic              accept;
    logic [P_W-1:0]    a_x;
    logic [P_W-1:0]    b_x;
    logic [P_W-1:0]    prod;

    logic              s1_valid;
    logic              s1_last;
    logic              st_valid;
    logic              st_clear;
    logic              st_last;
    logic [P_W-1:0]    st_p;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  lim;
    logic [ACC_W-1:0]  res_data;
    logic              res_valid;
    logic              sat_flag;
    logic              sat_next;
    logic              restart;
    logic              start;
    logic              ovf;
    logic              clamp;
    logic [S_W-1:0]    p_x;
    logic [S_W-1:0]    acc_x;
    logic [S_W-1:0]    sum;

    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic              fwd_valid;

    // A pending last in stage 1 blocks intake so it can never overwrite an unaccepted result.
    assign in_ready = !((res_valid && !bus.res_ready) || (s1_valid && s1_last));
    assign accept   = bus.in_valid && in_ready;

    // Low P_W bits of the product of extended operands are exact for both signed and unsigned.
    assign a_x  = {{DATA_W{SGN & bus.a[DATA_W-1]}}, bus.a};
    assign b_x  = {{DATA_W{SGN & bus.b[DATA_W-1]}}, bus.b};
    assign prod = a_x * b_x;

    generate
        if (MUL_STAGE != 0) begin : g_mul_reg
            logic [P_W-1:0] s1_p;
            logic           s1_clear;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    s1_clear <= 1'b0;
                    s1_last  <= 1'b0;
                    s1_p     <= '0;
                end else begin
                    s1_valid <= accept;
                    if (accept) begin
                        s1_p     <= prod;
                        s1_clear <= bus.in_clear;
                        s1_last  <= bus.in_last;
                    end
                end
            end

            assign st_valid = s1_valid;
            assign st_clear = s1_clear;
            assign st_last  = s1_last;
            assign st_p     = s1_p;
        end else begin : g_mul_comb
            assign s1_valid = 1'b0;
            assign s1_last  = 1'b0;
            assign st_valid = accept;
            assign st_clear = bus.in_clear;
            assign st_last  = bus.in_last;
            assign st_p     = prod;
        end
    endgenerate

    always_comb begin
        start = st_clear | restart;
        p_x   = {{(S_W-P_W){SGN & st_p[P_W-1]}}, st_p};
        acc_x = {{(S_W-ACC_W){SGN & acc[ACC_W-1]}}, acc};
        sum   = start ? p_x : (acc_x + p_x);
        ovf   = 1'b0;
        lim   = '1;
        if (SGN) begin
            // In range only when every bit from the accumulator sign bit upward agrees.
            ovf = (sum[S_W-1:ACC_W-1] != '0) && (sum[S_W-1:ACC_W-1] != '1);
            lim = sum[S_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            ovf = |sum[S_W-1:ACC_W];
        end
        clamp    = SAT && ovf;
        acc_next = clamp ? lim : sum[ACC_W-1:0];
        sat_next = clamp | (sat_flag & !start);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            sat_flag  <= 1'b0;
            restart   <= 1'b0;
            res_data  <= '0;
            res_valid <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            fwd_valid <= 1'b0;
        end else begin
            fwd_valid <= accept;
            if (accept) begin
                a_out <= bus.a;
                b_out <= bus.b;
            end
            if (res_valid && bus.res_ready) begin
                res_valid <= 1'b0;
            end
            if (st_valid) begin
                acc      <= acc_next;
                sat_flag <= sat_next;
                restart  <= st_last;
                if (st_last) begin
                    res_data  <= acc_next;
                    res_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.a_out     = a_out;
    assign bus.b_out     = b_out;
    assign bus.fwd_valid = fwd_valid;
    assign bus.c         = acc;
    assign bus.res_data  = res_data;
    assign bus.res_valid = res_valid;
    assign bus.sat_flag  = sat_flag;
endmodule

// File: tb/tb_pe_mac_pipe.sv
// Bench for pe_mac_pipe: three configurations driven with directed beats; results are
// checked by a queue-based scoreboard, running state by directed compares.
module tb_pe_mac_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic        vld [3];
    logic        clr [3];
    logic        lst [3];
    logic        rr  [3];
    logic [31:0] av  [3];
    logic [31:0] bv  [3];
    logic        rdy [3];
    logic        fwd [3];
    logic        rv  [3];
    logic        sat [3];
    logic [31:0] aout[3];
    logic [31:0] bout[3];
    logic [31:0] cv  [3];
    logic [31:0] rd  [3];
    logic        prv [3];

    int checks = 0;
    int passed = 0;

    typedef struct {
        int          dut;
        logic [31:0] val;
    } sb_t;
    sb_t sbq[$];

    pe_mac_if #(.DATA_W(32), .ACC_W(32)) ifs[3] ();

    for (genvar g = 0; g < 3; g++) begin : g_con
        assign ifs[g].in_valid  = vld[g];
        assign ifs[g].a         = av[g];
        assign ifs[g].b         = bv[g];
        assign ifs[g].in_clear  = clr[g];
        assign ifs[g].in_last   = lst[g];
        assign ifs[g].res_ready = rr[g];
        assign rdy[g]  = ifs[g].in_ready;
        assign fwd[g]  = ifs[g].fwd_valid;
        assign rv[g]   = ifs[g].res_valid;
        assign sat[g]  = ifs[g].sat_flag;
        assign aout[g] = ifs[g].a_out;
        assign bout[g] = ifs[g].b_out;
        assign cv[g]   = ifs[g].c;
        assign rd[g]   = ifs[g].res_data;
    end

    // u0: unsigned saturating, combinational product
    pe_mac_pipe #(.DATA_W(32), .ACC_W(32), .SIGNED(0), .SATURATE(1), .MUL_STAGE(0))
        u0 (.clk(clk), .rst(rst[0]), .bus(ifs[0]));
    // u1: unsigned wrapping
    pe_mac_pipe #(.DATA_W(32), .ACC_W(32), .SIGNED(0), .SATURATE(0), .MUL_STAGE(0))
        u1 (.clk(clk), .rst(rst[1]), .bus(ifs[1]));
    // u2: signed saturating, registered product
    pe_mac_pipe #(.DATA_W(32), .ACC_W(32), .SIGNED(1), .SATURATE(1), .MUL_STAGE(1))
        u2 (.clk(clk), .rst(rst[2]), .bus(ifs[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic push(input int k, input logic [31:0] v);
        sb_t e;
        e.dut = k;
        e.val = v;
        sbq.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic beat(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic l);
        int n;
        av[k] = a; bv[k] = b; clr[k] = c; lst[k] = l; vld[k] = 1'b1;
        n = 0;
        while (!rdy[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[k]) begin
            checks++;
            $display("FAIL beat_timeout dut%0d: in_ready stayed 0, expected 1", k);
        end
        @(posedge clk);
        @(negedge clk);
        vld[k] = 1'b0; clr[k] = 1'b0; lst[k] = 1'b0;
    endtask

    // Scoreboard monitor: a result is new when res_valid rises or is reloaded on a handshake edge.
    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (rv[k] && (!prv[k] || rr[k])) begin
                if (sbq.size() == 0) begin
                    checks++;
                    $display("FAIL sb_unexpected dut%0d: got res_data %h, expected no result", k, rd[k]);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("sb_dut", k, e.dut);
                    chk("sb_res_data", rd[k], e.val);
                end
            end
            prv[k] = rv[k];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; vld[k] = 1'b0; clr[k] = 1'b0; lst[k] = 1'b0;
            rr[k] = 1'b1; av[k] = '0; bv[k] = '0; prv[k] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("rst_c", cv[0], 32'h0);
        chk("rst_res_valid", {31'b0, rv[0]}, 32'h0);
        chk("rst_in_ready", {31'b0, rdy[0]}, 32'h1);
        chk("rst_fwd_valid", {31'b0, fwd[0]}, 32'h0);
        chk("rst_c_u2", cv[2], 32'h0);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        // legacy accumulation
        beat(0, 32'd1, 32'd1, 1'b0, 1'b0);
        beat(0, 32'd2, 32'd2, 1'b0, 1'b0);
        beat(0, 32'd3, 32'd3, 1'b0, 1'b0);
        chk("legacy_c", cv[0], 32'h0000000E);
        chk("fwd_a_out", aout[0], 32'd3);
        chk("fwd_valid_hi", {31'b0, fwd[0]}, 32'h1);
        @(negedge clk);
        chk("fwd_valid_lo", {31'b0, fwd[0]}, 32'h0);
        chk("idle_c_hold", cv[0], 32'h0000000E);

        // clear, then a result held under backpressure
        rr[0] = 1'b0;
        beat(0, 32'd5, 32'd5, 1'b1, 1'b0);
        chk("clear_c", cv[0], 32'd25);
        chk("clear_sat", {31'b0, sat[0]}, 32'h0);
        push(0, 32'h1F);
        beat(0, 32'd2, 32'd3, 1'b0, 1'b1);
        chk("last_c", cv[0], 32'h1F);
        chk("last_res_valid", {31'b0, rv[0]}, 32'h1);
        chk("bp_in_ready", {31'b0, rdy[0]}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("bp_res_valid", {31'b0, rv[0]}, 32'h1);
        chk("bp_res_data", rd[0], 32'h1F);
        chk("bp_in_ready2", {31'b0, rdy[0]}, 32'h0);
        rr[0] = 1'b1;
        @(negedge clk);
        chk("ack_res_valid", {31'b0, rv[0]}, 32'h0);
        chk("ack_in_ready", {31'b0, rdy[0]}, 32'h1);
        beat(0, 32'd7, 32'd1, 1'b0, 1'b0);
        chk("restart_c", cv[0], 32'd7);

        // back-to-back results with res_ready high
        push(0, 32'd8);
        beat(0, 32'd1, 32'd1, 1'b0, 1'b1);
        push(0, 32'd4);
        beat(0, 32'd2, 32'd2, 1'b1, 1'b1);
        push(0, 32'd9);
        beat(0, 32'd3, 32'd3, 1'b1, 1'b1);
        chk("b2b_res_valid", {31'b0, rv[0]}, 32'h1);
        chk("b2b_res_data", rd[0], 32'd9);
        @(negedge clk);
        chk("b2b_drop", {31'b0, rv[0]}, 32'h0);

        // unsigned saturation
        beat(0, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
        chk("umax_exact_c", cv[0], 32'hFFFFFFFF);
        chk("umax_exact_sat", {31'b0, sat[0]}, 32'h0);
        beat(0, 32'hFFFFFFF0, 32'd1, 1'b1, 1'b0);
        beat(0, 32'h20, 32'd1, 1'b0, 1'b0);
        chk("usat_c", cv[0], 32'hFFFFFFFF);
        chk("usat_flag", {31'b0, sat[0]}, 32'h1);
        beat(0, 32'd1, 32'd1, 1'b1, 1'b0);
        chk("usat_clear_c", cv[0], 32'd1);
        chk("usat_clear_flag", {31'b0, sat[0]}, 32'h0);
        push(0, 32'hFFFFFFFF);
        beat(0, 32'h10000, 32'h10000, 1'b1, 1'b1);
        chk("usat_prod_flag", {31'b0, sat[0]}, 32'h1);
        beat(0, 32'd2, 32'd2, 1'b0, 1'b0);
        chk("usat_restart_c", cv[0], 32'd4);
        chk("usat_restart_flag", {31'b0, sat[0]}, 32'h0);

        // wrapping variant
        beat(1, 32'hFFFFFFF0, 32'd1, 1'b1, 1'b0);
        beat(1, 32'h20, 32'd1, 1'b0, 1'b0);
        chk("wrap_c", cv[1], 32'h10);
        chk("wrap_sat", {31'b0, sat[1]}, 32'h0);
        push(1, 32'h0);
        beat(1, 32'h10000, 32'h10000, 1'b1, 1'b1);
        chk("wrap_prod_c", cv[1], 32'h0);

        // signed, registered product
        beat(2, 32'hFFFFFFFD, 32'd4, 1'b1, 1'b0);
        chk("s_fwd_a", aout[2], 32'hFFFFFFFD);
        chk("s_fwd_b", bout[2], 32'd4);
        chk("s_fwd_valid", {31'b0, fwd[2]}, 32'h1);
        chk("s_c_latency", cv[2], 32'h0);
        @(negedge clk);
        chk("s_c", cv[2], 32'hFFFFFFF4);
        chk("s_fwd_drop", {31'b0, fwd[2]}, 32'h0);
        beat(2, 32'h7FFFFFFF, 32'd1, 1'b1, 1'b0);
        beat(2, 32'd1, 32'd1, 1'b0, 1'b0);
        @(negedge clk);
        chk("s_max_c", cv[2], 32'h7FFFFFFF);
        chk("s_max_sat", {31'b0, sat[2]}, 32'h1);
        beat(2, 32'h80000000, 32'd1, 1'b1, 1'b0);
        push(2, 32'h80000000);
        beat(2, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);
        chk("s1_last_in_ready", {31'b0, rdy[2]}, 32'h0);
        @(negedge clk);
        chk("s_min_c", cv[2], 32'h80000000);
        chk("s_min_sat", {31'b0, sat[2]}, 32'h1);
        chk("s_min_in_ready", {31'b0, rdy[2]}, 32'h1);

        // reset with a last beat still in stage 1
        beat(2, 32'd5, 32'd5, 1'b1, 1'b1);
        rst[2] = 1'b1;
        #1;
        chk("arst_c", cv[2], 32'h0);
        chk("arst_res_valid", {31'b0, rv[2]}, 32'h0);
        chk("arst_in_ready", {31'b0, rdy[2]}, 32'h1);
        @(negedge clk);
        rst[2] = 1'b0;
        repeat (4) @(negedge clk);
        chk("arst_no_result", {31'b0, rv[2]}, 32'h0);
        chk("arst_c_after", cv[2], 32'h0);

        repeat (3) @(negedge clk);
        chk("sb_drain", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
